// File: rtl/irq_prio_ctrl_pkg.sv
// Shared constants and types for the prioritising interrupt controller.
package irq_prio_ctrl_pkg;

    localparam int ADR_W = 3;
    localparam int DAT_W = 32;
    localparam int LVL_W = 3;

    // Word addresses of the register file
    localparam logic [ADR_W-1:0] ADR_PEND = 3'd0;
    localparam logic [ADR_W-1:0] ADR_MASK = 3'd1;
    localparam logic [ADR_W-1:0] ADR_EDGE = 3'd2;
    localparam logic [ADR_W-1:0] ADR_LVL  = 3'd3;
    localparam logic [ADR_W-1:0] ADR_STAT = 3'd4;

    // STAT field positions
    localparam int STAT_IPL_LSB = 0;
    localparam int STAT_IDX_LSB = 8;
    localparam int STAT_ANY_BIT = 16;

    // Result of the priority search
    typedef struct packed {
        logic [LVL_W-1:0] ipl;
        logic [2:0]       idx;
        logic             any;
    } prio_t;

    // Expand byte-lane selects into a bit mask
    function automatic logic [DAT_W-1:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/irq_prio_ctrl_if.sv
// Wishbone slave bus bundle for the interrupt controller register file.
interface irq_prio_ctrl_if;
    import irq_prio_ctrl_pkg::*;

    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic             wb_we_i;
    logic [ADR_W-1:0] wb_adr_i;
    logic [3:0]       wb_sel_i;
    logic [DAT_W-1:0] wb_dat_i;
    logic [DAT_W-1:0] wb_dat_o;
    logic             wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/irq_prio_ctrl_src_cell.sv
// One interrupt source: optional synchroniser, edge history and pending bit.
module irq_prio_ctrl_src_cell
    import irq_prio_ctrl_pkg::*;
#(
    parameter int SYNC_EN = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic int_i,
    input  logic edge_mode_i,
    input  logic edge_chg_i,
    input  logic w1c_i,
    output logic pend_o
);

    logic s2;
    logic s3_q;
    logic pend_q, pend_d;

    if (SYNC_EN != 0) begin : g_sync
        logic s1_q, s2_q;
        // Two-flop synchroniser for requests from foreign clock domains
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= int_i;
                s2_q <= s1_q;
            end
        end
        assign s2 = s2_q;
    end else begin : g_direct
        assign s2 = int_i;
    end

    // Pending next state; a fresh rising edge beats a simultaneous clear
    always_comb begin
        pend_d = pend_q;
        if (edge_chg_i) begin
            pend_d = 1'b0;
        end else if (edge_mode_i) begin
            pend_d = (pend_q & ~w1c_i) | (s2 & ~s3_q);
        end else begin
            pend_d = s2;
        end
    end

    // Edge history and pending register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s3_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            s3_q   <= s2;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/irq_prio_ctrl.sv
// Prioritising interrupt controller: Wishbone register file, per-source
// pending cells and a priority search feeding the registered 68k IPL.
module irq_prio_ctrl
    import irq_prio_ctrl_pkg::*;
#(
    parameter int NSRC    = 7,
    parameter int SYNC_EN = 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    irq_prio_ctrl_if.slave      bus,
    input  logic [NSRC-1:0]     int_i,
    output logic [LVL_W-1:0]    ipl_o
);

    localparam int LVL_BITS = LVL_W * NSRC;

    logic [NSRC-1:0]     mask_q, mask_d;
    logic [NSRC-1:0]     edge_q, edge_d;
    logic [LVL_BITS-1:0] lvl_q, lvl_d;
    logic [NSRC-1:0]     edge_chg, w1c, pend;
    logic                ack_q;
    logic [DAT_W-1:0]    dat_q, dat_d;
    prio_t               win_q, win_d;

    logic             acc, wr;
    logic [DAT_W-1:0] bmask, wdat, rdata;
    logic             unused_bits;

    assign acc   = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
    assign wr    = acc & bus.wb_we_i;
    assign bmask = byte_mask(bus.wb_sel_i);
    assign wdat  = bus.wb_dat_i & bmask;
    assign unused_bits = ^{wdat, bmask};

    // Register writes commit on the acknowledge edge, honouring byte lanes
    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        lvl_d  = lvl_q;
        w1c    = '0;
        if (wr) begin
            case (bus.wb_adr_i)
                ADR_PEND: w1c    = wdat[NSRC-1:0] & edge_q;
                ADR_MASK: mask_d = (mask_q & ~bmask[NSRC-1:0]) | wdat[NSRC-1:0];
                ADR_EDGE: edge_d = (edge_q & ~bmask[NSRC-1:0]) | wdat[NSRC-1:0];
                ADR_LVL:  lvl_d  = (lvl_q & ~bmask[LVL_BITS-1:0]) | wdat[LVL_BITS-1:0];
                default:  ;
            endcase
        end
    end

    assign edge_chg = edge_q ^ edge_d;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        irq_prio_ctrl_src_cell #(.SYNC_EN(SYNC_EN)) u_cell (
            .clk_i       (wb_clk_i),
            .rst_n_i     (wb_rst_n_i),
            .int_i       (int_i[i]),
            .edge_mode_i (edge_q[i]),
            .edge_chg_i  (edge_chg[i]),
            .w1c_i       (w1c[i]),
            .pend_o      (pend[i])
        );
    end

    // Highest level among active sources; strict compare keeps the lowest index on ties
    always_comb begin
        win_d = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (pend[i] && mask_q[i] && (lvl_q[LVL_W*i +: LVL_W] > win_d.ipl)) begin
                win_d.ipl = lvl_q[LVL_W*i +: LVL_W];
                win_d.idx = 3'(i);
                win_d.any = 1'b1;
            end
        end
    end

    // Read multiplexer; unused bits and addresses return zero
    always_comb begin
        rdata = '0;
        case (bus.wb_adr_i)
            ADR_PEND: rdata[NSRC-1:0]     = pend;
            ADR_MASK: rdata[NSRC-1:0]     = mask_q;
            ADR_EDGE: rdata[NSRC-1:0]     = edge_q;
            ADR_LVL:  rdata[LVL_BITS-1:0] = lvl_q;
            ADR_STAT: begin
                rdata[STAT_IPL_LSB +: LVL_W] = win_q.ipl;
                rdata[STAT_IDX_LSB +: 3]     = win_q.idx;
                rdata[STAT_ANY_BIT]          = win_q.any;
            end
            default:  ;
        endcase
        dat_d = acc ? rdata : '0;
    end

    // Config registers, bus response and registered priority result
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            mask_q <= '0;
            edge_q <= '0;
            lvl_q  <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            win_q  <= '0;
        end else begin
            mask_q <= mask_d;
            edge_q <= edge_d;
            lvl_q  <= lvl_d;
            ack_q  <= acc;
            dat_q  <= dat_d;
            win_q  <= win_d;
        end
    end

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_dat_o = dat_q;
    assign ipl_o        = win_q.ipl;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Self-checking bench for irq_prio_ctrl: directed scenarios plus randomized
// configuration/request traffic against a register-level reference model.
module tb_irq_prio_ctrl;
    import irq_prio_ctrl_pkg::*;

    localparam int NSRC = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NSRC-1:0] int_i;
    logic [2:0]      ipl;

    irq_prio_ctrl_if bus();

    irq_prio_ctrl #(.NSRC(NSRC), .SYNC_EN(1)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus),
        .int_i      (int_i),
        .ipl_o      (ipl)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Scoreboard: one entry per bus transfer, popped when ack is seen
    logic [31:0] exp_q[$];
    bit          rd_q[$];
    string       tag_q[$];

    // Reference model state
    logic [NSRC-1:0]   m_mask, m_edge, m_epend, m_int;
    logic [3*NSRC-1:0] m_lvl;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [NSRC-1:0] m_pend();
        return (m_epend & m_edge) | (m_int & ~m_edge);
    endfunction

    // Search levels from 7 downward; first source found at a level wins
    function automatic logic [31:0] m_stat();
        logic [NSRC-1:0] p;
        logic [31:0]     r;
        logic [2:0]      lv;
        bit              found;
        p = m_pend();
        r = '0;
        found = 0;
        for (int l = 7; l >= 1; l--) begin
            for (int i = 0; i < NSRC; i++) begin
                lv = m_lvl[3*i +: 3];
                if (!found && p[i] && m_mask[i] && (int'(lv) == l)) begin
                    found = 1;
                    r[2:0]  = 3'(l);
                    r[10:8] = 3'(i);
                    r[16]   = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] m_ipl();
        logic [31:0] s;
        s = m_stat();
        return {29'b0, s[2:0]};
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] adr);
        logic [31:0] r;
        r = '0;
        case (adr)
            3'd0: r[NSRC-1:0]   = m_pend();
            3'd1: r[NSRC-1:0]   = m_mask;
            3'd2: r[NSRC-1:0]   = m_edge;
            3'd3: r[3*NSRC-1:0] = m_lvl;
            3'd4: r             = m_stat();
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic m_write(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0]     bm, nv;
        logic [NSRC-1:0] ne;
        bm = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        case (adr)
            3'd0: m_epend = m_epend & ~(dat[NSRC-1:0] & bm[NSRC-1:0] & m_edge);
            3'd1: begin
                nv = ({25'b0, m_mask} & ~bm) | (dat & bm);
                m_mask = nv[NSRC-1:0];
            end
            3'd2: begin
                nv = ({25'b0, m_edge} & ~bm) | (dat & bm);
                ne = nv[NSRC-1:0];
                m_epend = m_epend & ~(ne ^ m_edge);
                m_edge = ne;
            end
            3'd3: begin
                nv = ({11'b0, m_lvl} & ~bm) | (dat & bm);
                m_lvl = nv[3*NSRC-1:0];
            end
            default: ;
        endcase
    endtask

    task automatic m_reset();
        m_mask = '0; m_edge = '0; m_epend = '0; m_lvl = '0;
    endtask

    task automatic set_int(input logic [NSRC-1:0] v);
        m_epend = m_epend | (v & ~m_int & m_edge);
        m_int   = v;
        int_i   = v;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        wait_edges(6);
    endtask

    task automatic bus_xfer(input logic [2:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input bit we);
        int k;
        @(posedge clk);
        #1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_sel_i = sel;
        bus.wb_dat_i = dat;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.wb_ack_o && k < 8);
        check("ack_seen", {31'b0, bus.wb_ack_o}, 32'd1);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic reg_wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        exp_q.push_back(32'd0);
        rd_q.push_back(1'b0);
        tag_q.push_back("wr");
        m_write(adr, dat, sel);
        bus_xfer(adr, dat, sel, 1'b1);
    endtask

    task automatic reg_rd(input logic [2:0] adr, input string tag);
        exp_q.push_back(m_read(adr));
        rd_q.push_back(1'b1);
        tag_q.push_back(tag);
        bus_xfer(adr, 32'd0, 4'hF, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every acknowledge
    bit ack_prev = 1'b0;
    always @(negedge clk) begin
        logic [31:0] e;
        bit          r;
        string       t;
        if (bus.wb_ack_o) begin
            check("ack_single_cycle", {31'b0, ack_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
            end else begin
                e = exp_q.pop_front();
                r = rd_q.pop_front();
                t = tag_q.pop_front();
                if (r) check(t, bus.wb_dat_o, e);
            end
        end
        ack_prev = bus.wb_ack_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = '0;   bus.wb_sel_i = '0;   bus.wb_dat_i = '0;
        int_i = '0; m_int = '0; m_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_ipl", 32'(ipl), 32'd0);
        check("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'd0);

        // Reset asserted in the middle of a bus cycle with an active source
        reg_wr(ADR_LVL, 32'h5 << 6, 4'hF);
        reg_wr(ADR_MASK, 32'h04, 4'hF);
        set_int(7'h04);
        settle();
        check("pre_rst_ipl", 32'(ipl), m_ipl());
        @(posedge clk);
        #1;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_adr_i = ADR_LVL;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("midrst_ipl", 32'(ipl), 32'd0);
        @(posedge clk);
        #1;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        set_int('0);
        m_reset();
        wait_edges(2);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) reg_rd(3'(a), $sformatf("rst_reg%0d", a));

        // Level source latency: rise and fall both take four clocks
        reg_wr(ADR_LVL, 32'h5 << 6, 4'hF);
        reg_wr(ADR_MASK, 32'h04, 4'hF);
        reg_wr(ADR_EDGE, 32'h0, 4'hF);
        settle();
        check("lvl_idle_ipl", 32'(ipl), 32'd0);
        set_int(7'h04);
        wait_edges(3);
        check("lvl_rise_clk3", 32'(ipl), 32'd0);
        wait_edges(1);
        check("lvl_rise_clk4", 32'(ipl), 32'd5);
        reg_rd(ADR_STAT, "lvl_stat");
        set_int(7'h00);
        wait_edges(3);
        check("lvl_fall_clk3", 32'(ipl), 32'd5);
        wait_edges(1);
        check("lvl_fall_clk4", 32'(ipl), 32'd0);

        // Edge source: one-clock pulse latches, W1C clears one clock after ack
        reg_wr(ADR_LVL, 32'h3, 4'hF);
        reg_wr(ADR_MASK, 32'h01, 4'hF);
        reg_wr(ADR_EDGE, 32'h01, 4'hF);
        settle();
        set_int(7'h01);
        wait_edges(1);
        set_int(7'h00);
        settle();
        reg_rd(ADR_PEND, "edge_pend");
        check("edge_ipl", 32'(ipl), 32'd3);
        wait_edges(4);
        check("edge_ipl_held", 32'(ipl), 32'd3);
        reg_wr(ADR_PEND, 32'h01, 4'hF);
        check("w1c_ipl_at_ack", 32'(ipl), 32'd3);
        wait_edges(1);
        check("w1c_ipl_after", 32'(ipl), 32'd0);
        reg_rd(ADR_PEND, "w1c_pend");

        // Priority: highest level wins, ties go to the lowest index
        reg_wr(ADR_EDGE, 32'h0, 4'hF);
        reg_wr(ADR_LVL, (32'h4 << 3) | (32'h6 << 9) | (32'h6 << 12), 4'hF);
        reg_wr(ADR_MASK, 32'h1A, 4'hF);
        set_int(7'h1A);
        settle();
        check("prio_ipl", 32'(ipl), 32'd6);
        reg_rd(ADR_STAT, "prio_stat_idx3");
        reg_wr(ADR_MASK, 32'h12, 4'hF);
        reg_rd(ADR_STAT, "prio_stat_idx4");
        reg_wr(ADR_MASK, 32'h02, 4'hF);
        check("mask_ipl_at_ack", 32'(ipl), 32'd6);
        wait_edges(1);
        check("mask_ipl_after", 32'(ipl), 32'd4);
        set_int(7'h00);
        settle();
        reg_rd(ADR_STAT, "idle_stat");

        // Simultaneous W1C and new edge: the new edge must survive
        reg_wr(ADR_EDGE, 32'h01, 4'hF);
        reg_wr(ADR_LVL, 32'h3, 4'hF);
        reg_wr(ADR_MASK, 32'h01, 4'hF);
        settle();
        set_int(7'h01);
        wait_edges(1);
        set_int(7'h00);
        settle();
        set_int(7'h01);
        wait_edges(1);
        reg_wr(ADR_PEND, 32'h01, 4'hF);
        m_epend[0] = 1'b1;
        reg_rd(ADR_PEND, "w1c_vs_edge");
        set_int(7'h00);
        settle();

        // Byte lanes and unused addresses
        reg_wr(ADR_LVL, 32'hFFFF_FFFF, 4'b0001);
        reg_rd(ADR_LVL, "lvl_byte0");
        reg_rd(3'd6, "adr6_read");
        reg_wr(3'd6, 32'hFFFF_FFFF, 4'hF);
        reg_rd(3'd6, "adr6_after_write");
        reg_rd(3'd5, "adr5_read");
        reg_rd(3'd7, "adr7_read");

        // Randomized configuration and request traffic
        for (int it = 0; it < 30; it++) begin
            reg_wr(ADR_LVL, $urandom, 4'($urandom_range(0, 15)));
            reg_wr(ADR_MASK, $urandom, 4'hF);
            reg_wr(ADR_EDGE, $urandom, 4'hF);
            for (int k = 0; k < 4; k++) begin
                r = $urandom;
                set_int(r[NSRC-1:0]);
                wait_edges($urandom_range(1, 2));
            end
            settle();
            check("rnd_ipl", 32'(ipl), m_ipl());
            reg_rd(ADR_PEND, "rnd_pend");
            reg_rd(ADR_STAT, "rnd_stat");
            if ($urandom_range(0, 1) == 1) begin
                reg_wr(ADR_PEND, $urandom, 4'hF);
                settle();
                reg_rd(ADR_PEND, "rnd_pend_w1c");
                reg_rd(ADR_STAT, "rnd_stat_w1c");
            end
        end

        wait_edges(3);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
